// File: rtl/cube_move_seq.sv
// cube_move_seq: opcode FIFO and sequencer that drives the 2x2 cube ALU one move per cycle,
// then CHECKs against target. Optional macro CUBE_EARLY_EXIT_EN stops as soon as a result equals target.
module cube_move_seq #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   input  logic [23:0]      load_state,
   input  logic [23:0]      target,
   input  logic             mv_valid,
   input  logic [3:0]       mv_op,
   output logic             mv_ready,
   input  logic             start,
   output logic [3:0]       alu_op,
   output logic [23:0]      alu_ina,
   output logic [23:0]      alu_inb,
   input  logic [23:0]      alu_out,
   input  logic             alu_zf,
   output logic [23:0]      state,
   output logic [CNT_W-1:0] move_cnt,
   output logic             busy,
   output logic             done,
   output logic             match,
   output logic             err
);

   // state   | meaning
   // S_IDLE  | ALU in STORE; accepts load and start
   // S_RUN   | one queued move per cycle, result written back to state
   // S_CHECK | ALU compares state with target, match captured
   // S_DONE  | one-cycle done pulse
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} fsm_t;

   localparam int AW = $clog2(DEPTH);

   localparam logic [3:0] OP_STORE = 4'h9;
   localparam logic [3:0] OP_CHECK = 4'h7;

   fsm_t fsm, fsm_nxt;

   logic [3:0]  mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt;
   logic        empty, full, legal_op, push, push_ok, pop, early_hit;
   logic        load_ok;
   logic [3:0]  head;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign mv_ready = !full;
   assign head     = mem[rd_ptr[AW-1:0]];

   always_comb begin
      legal_op = 1'b0;
      case (mv_op)
         4'hb, 4'hc, 4'hd, 4'he, 4'hf, 4'h5, 4'h4, 4'h3: legal_op = 1'b1;
         default:                                         legal_op = 1'b0;
      endcase
   end

   assign push       = mv_valid & mv_ready;
   assign push_ok    = push & legal_op;
   assign pop        = (fsm == S_RUN) && !empty;
   assign load_ok    = (fsm == S_IDLE) && load_valid;
   assign wr_ptr_nxt = wr_ptr + (AW+1)'(push_ok);

`ifdef CUBE_EARLY_EXIT_EN
   assign early_hit = pop && (alu_out == target);
`else
   assign early_hit = 1'b0;
`endif

   // Contents need no reset: pointers alone define occupancy.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= mv_op;
   end

   // An early-exit flush also discards a move pushed in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr_nxt;
         if (early_hit) rd_ptr <= wr_ptr_nxt;
         else           rd_ptr <= rd_ptr + (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm <= S_IDLE;
      else        fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         S_IDLE:  if (start) fsm_nxt = S_RUN;
         S_RUN: begin
            if (empty)          fsm_nxt = S_CHECK;
            else if (early_hit) fsm_nxt = S_DONE;
         end
         S_CHECK: fsm_nxt = S_DONE;
         S_DONE:  fsm_nxt = S_IDLE;
         default: fsm_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      alu_op = OP_STORE;
      busy   = 1'b0;
      done   = 1'b0;
      case (fsm)
         S_RUN: begin
            busy = 1'b1;
            if (!empty) alu_op = head;
         end
         S_CHECK: begin
            busy   = 1'b1;
            alu_op = OP_CHECK;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign alu_ina = state;
   assign alu_inb = target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= '0;
         move_cnt <= '0;
      end else if (load_ok) begin
         state    <= load_state;
         move_cnt <= '0;
      end else if (pop) begin
         state <= alu_out;
         if (move_cnt != {CNT_W{1'b1}}) move_cnt <= move_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               match <= 1'b0;
      else if (load_ok)                         match <= 1'b0;
      else if ((fsm == S_IDLE) && start)        match <= 1'b0;
      else if (fsm == S_CHECK)                  match <= alu_zf;
      else if (early_hit)                       match <= 1'b1;
   end

   // A rejected opcode in the same cycle as a load still flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  err <= 1'b0;
      else if (push && !legal_op)  err <= 1'b1;
      else if (load_ok)            err <= 1'b0;
   end

endmodule

// File: tb/tb_cube_move_seq.sv
// Self-checking bench for cube_move_seq: corner-permutation ALU model plus a queue-based
// reference of the move sequence, with random states, opcodes and targets.
module tb_cube_move_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_valid, mv_valid, start;
   logic [23:0] load_state, target;
   logic [3:0]  mv_op;
   logic        mv_ready;
   logic [3:0]  alu_op;
   logic [23:0] alu_ina, alu_inb, alu_out;
   logic        alu_zf;
   logic [23:0] state;
   logic [7:0]  move_cnt;
   logic        busy, done, match, err;

   int total = 0;
   int bad   = 0;

   cube_move_seq #(.DEPTH(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_state(load_state),
      .target(target), .mv_valid(mv_valid), .mv_op(mv_op), .mv_ready(mv_ready),
      .start(start), .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb),
      .alu_out(alu_out), .alu_zf(alu_zf), .state(state), .move_cnt(move_cnt),
      .busy(busy), .done(done), .match(match), .err(err)
   );

   always #5 clk = ~clk;

   // Quarter turn about one axis: two 4-cycles of corner slots.
   function automatic logic [23:0] quarter(input int axis, input logic [23:0] s);
      int c0[4];
      int c1[4];
      logic [23:0] r;
      r = s;
      case (axis)
         0:       begin c0 = '{0, 2, 6, 4}; c1 = '{1, 3, 7, 5}; end
         1:       begin c0 = '{0, 1, 5, 4}; c1 = '{2, 3, 7, 6}; end
         default: begin c0 = '{0, 1, 3, 2}; c1 = '{4, 5, 7, 6}; end
      endcase
      for (int k = 0; k < 4; k++) begin
         r[c0[(k+1)%4]*3 +: 3] = s[c0[k]*3 +: 3];
         r[c1[(k+1)%4]*3 +: 3] = s[c1[k]*3 +: 3];
      end
      return r;
   endfunction

   function automatic logic [23:0] alu_fn(input logic [3:0] op, input logic [23:0] a);
      int axis, turns;
      logic [23:0] r;
      axis = 0; turns = 0; r = a;
      case (op)
         4'hb: begin axis = 0; turns = 1; end
         4'hc: begin axis = 0; turns = 2; end
         4'hd: begin axis = 0; turns = 3; end
         4'he: begin axis = 1; turns = 1; end
         4'hf: begin axis = 1; turns = 2; end
         4'h5: begin axis = 1; turns = 3; end
         4'h4: begin axis = 2; turns = 1; end
         4'h3: begin axis = 2; turns = 2; end
         default: turns = 0;
      endcase
      for (int t = 0; t < turns; t++) r = quarter(axis, r);
      return r;
   endfunction

   always_comb begin
      alu_out = alu_fn(alu_op, alu_ina);
      alu_zf  = (alu_op == 4'h7) && (alu_ina == alu_inb);
   end

   logic [3:0]  legal_ops [8] = '{4'hb, 4'hc, 4'hd, 4'he, 4'hf, 4'h5, 4'h4, 4'h3};
   logic [3:0]  q[$];
   logic [23:0] m_state, exp_state, s_tmp;
   int          m_cnt, exec_n, exp_cycles, cyc;
   logic        exp_match, early, got_done, accepted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [23:0] s);
      load_valid = 1'b1;
      load_state = s;
      tick();
      load_valid = 1'b0;
      m_state = s;
      m_cnt = 0;
   endtask

   task automatic push(input logic [3:0] op);
      mv_valid = 1'b1;
      mv_op = op;
      tick();
      mv_valid = 1'b0;
      for (int i = 0; i < 8; i++) if (legal_ops[i] == op) begin q.push_back(op); break; end
   endtask

   task automatic model_run(input logic [23:0] tgt);
      logic [23:0] s;
      s = m_state; exec_n = 0; early = 1'b0;
      foreach (q[i]) begin
         if (!early) begin
            s = alu_fn(q[i], s);
            exec_n++;
`ifdef CUBE_EARLY_EXIT_EN
            if (s == tgt) early = 1'b1;
`endif
         end
      end
      exp_state  = s;
      exp_match  = early ? 1'b1 : (s == tgt);
      exp_cycles = early ? exec_n : exec_n + 2;
   endtask

   // Waits for done, counting clock edges since the edge that sampled start.
   task automatic wait_done(input bit with_junk);
      got_done = 1'b0;
      cyc = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (done) begin got_done = 1'b1; break; end
         @(posedge clk);
         cyc++;
         #1;
         if (with_junk && cyc == 1 && exp_cycles >= 2) begin
            load_valid = 1'b1; load_state = ~m_state; start = 1'b1;
         end else begin
            load_valid = 1'b0; start = 1'b0;
         end
      end
      load_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic finish_run(input string tag, input bit chk_cycles);
      chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
      if (chk_cycles) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
      chk({tag, "_state"}, 32'(state), 32'(exp_state));
      m_cnt = m_cnt + exec_n;
      chk({tag, "_cnt"}, 32'(move_cnt), 32'(m_cnt));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      tick();
      chk({tag, "_match"}, 32'(match), 32'(exp_match));
      chk({tag, "_done_once"}, 32'(done), 32'd0);
      m_state = exp_state;
      q.delete();
   endtask

   task automatic run_seq(input string tag);
      model_run(target);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(1'b1);
      finish_run(tag, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_state = '0; target = '0;
      mv_valid = 1'b0; mv_op = '0; start = 1'b0;
      m_state = '0; m_cnt = 0;
      #12;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cnt", 32'(move_cnt), 32'd0);
      chk("rst_flags", {28'd0, busy, done, match, err}, 32'd0);
      chk("rst_ready", 32'(mv_ready), 32'd1);
      chk("rst_aluop", 32'(alu_op), 32'h9);
      @(posedge clk); #1 rst_n = 1'b1;
      tick();

      // single RTX90 move
      target = 24'(($urandom));
      do_load(24'h0FAC68);
      push(4'hb);
      run_seq("t1");

      // four RTY90 turns return to the loaded state
      s_tmp = 24'($urandom);
      do_load(s_tmp);
      target = s_tmp;
      for (int i = 0; i < 4; i++) push(4'he);
      run_seq("t2");

      // RTX180 against the loaded state
      s_tmp = 24'($urandom);
      do_load(s_tmp);
      target = s_tmp;
      push(4'hc);
      run_seq("t3");

      // FIFO fill, back-pressure, then held ninth move
      do_load(24'($urandom));
      target = 24'($urandom);
      for (int i = 0; i < 8; i++) push(legal_ops[$urandom_range(0, 7)]);
      @(negedge clk);
      chk("t4_full_ready", 32'(mv_ready), 32'd0);
      #1;
      mv_op = legal_ops[$urandom_range(0, 7)];
      q.push_back(mv_op);
      mv_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      accepted = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (mv_ready) begin accepted = 1'b1; @(posedge clk); #1; break; end
      end
      mv_valid = 1'b0;
      chk("t4_ninth_accepted", 32'(accepted), 32'd1);
      model_run(target);
      exp_cycles = 0;
      wait_done(1'b0);
      finish_run("t4", 1'b0);
      chk("t4_err_clear", 32'(err), 32'd0);

      // illegal opcode is dropped and flagged
      do_load(24'($urandom));
      target = 24'($urandom);
      push(4'h2);
      push(4'hf);
      @(negedge clk);
      chk("t5_err_set", 32'(err), 32'd1);
      #1;
      run_seq("t5");
      chk("t5_err_sticky", 32'(err), 32'd1);
      do_load(m_state);
      chk("t5_err_load_clr", 32'(err), 32'd0);

      // random sequences, half of them aimed at their own final state
      for (int it = 0; it < 8; it++) begin
         do_load(24'($urandom));
         for (int i = 0; i < int'($urandom_range(0, 6)); i++) push(legal_ops[$urandom_range(0, 7)]);
         s_tmp = m_state;
         foreach (q[i]) s_tmp = alu_fn(q[i], s_tmp);
         target = ($urandom_range(0, 1) == 1) ? s_tmp : 24'($urandom);
         run_seq($sformatf("rnd%0d", it));
      end

      // asynchronous reset mid-sequence discards everything
      do_load(24'($urandom) | 24'h1);
      for (int i = 0; i < 4; i++) push(legal_ops[$urandom_range(0, 7)]);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_state", 32'(state), 32'd0);
      chk("mrst_cnt", 32'(move_cnt), 32'd0);
      chk("mrst_flags", {28'd0, busy, done, match, err}, 32'd0);
      chk("mrst_ready", 32'(mv_ready), 32'd1);
      @(posedge clk); #1 rst_n = 1'b1;
      q.delete();
      m_state = '0;
      m_cnt = 0;
      target = 24'($urandom) | 24'h100;
      run_seq("empty_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
